// File: rtl/wb_req_arbiter_if.sv
// Single-strobe 16-bit Wishbone link used by wb_req_arbiter for both the
// requesting masters and the shared slave bus.
// master: the side that issues requests; slave: the side that completes them.
interface wb_req_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_m2s;
  logic [15:0] dat_s2m;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_m2s,
    input  dat_s2m, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_m2s,
    output dat_s2m, ack, err
  );
endinterface

// File: rtl/wb_req_arbiter.sv
// wb_req_arbiter: two-master round-robin arbiter in front of one Wishbone slave.
// Each master's single-cycle request is latched, then forwarded as a
// one-cycle strobe; the ack/err and read data go back to the requester only.
// Optional bus timeout: define WB_REQ_ARBITER_TIMEOUT_EN to fail a transaction
// with err after TIMEOUT_CYCLES cycles without a slave response.
module wb_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_req_arbiter_if.slave         m0_io,
  wb_req_arbiter_if.slave         m1_io,
  wb_req_arbiter_if.master        wb_io,
  output logic [1:0]              grant_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..1023");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q;
  logic [1:0]  pend_q;
  logic [1:0]  p_we_q;
  logic [15:0] p_adr_q [2];
  logic [15:0] p_dat_q [2];
  logic        gnt_q;
  logic        last_q;
  logic [1:0]  grant_q;
  logic        wb_cyc_q, wb_stb_q, wb_we_q;
  logic [15:0] wb_adr_q, wb_dat_q;
  logic [15:0] m_dat_q [2];
  logic [1:0]  m_ack_q, m_err_q;

  logic [1:0]  req_stb;
  logic [1:0]  clr;
  logic        pick;
  logic        timeout;
  logic        done;
  logic        done_err;

  assign req_stb[0] = m0_io.cyc & m0_io.stb;
  assign req_stb[1] = m1_io.cyc & m1_io.stb;

  // Lone requester wins; on a tie, the master not served last wins.
  assign pick = pend_q[1] & (~pend_q[0] | ~last_q);

`ifdef WB_REQ_ARBITER_TIMEOUT_EN
  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] cnt_q;

  // Cycle counter: zero while idle, so it is zero on ISSUE entry.
  always_ff @(posedge clk) begin
    if (reset || state_q == StIdle) cnt_q <= '0;
    else                            cnt_q <= cnt_q + 10'd1;
  end

  assign timeout = (state_q != StIdle) && (cnt_q == TimeoutLast);
`else
  assign timeout = 1'b0;
`endif

  // A real slave response on the timeout cycle takes precedence over it.
  assign done     = (state_q != StIdle) && (wb_io.ack || wb_io.err || timeout);
  assign done_err = wb_io.err || (timeout && !wb_io.ack);
  assign clr[0]   = done & ~gnt_q;
  assign clr[1]   = done &  gnt_q;

  // Request capture; a new strobe may re-arm a slot in the cycle it is released.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        pend_q[n]  <= 1'b0;
        p_we_q[n]  <= 1'b0;
        p_adr_q[n] <= '0;
        p_dat_q[n] <= '0;
      end else if (req_stb[n] && (!pend_q[n] || clr[n])) begin
        pend_q[n]  <= 1'b1;
        p_we_q[n]  <= (n == 0) ? m0_io.we      : m1_io.we;
        p_adr_q[n] <= (n == 0) ? m0_io.adr     : m1_io.adr;
        p_dat_q[n] <= (n == 0) ? m0_io.dat_m2s : m1_io.dat_m2s;
      end else if (clr[n]) begin
        pend_q[n]  <= 1'b0;
      end
    end
  end

  // Arbitration FSM with all bus-facing and master-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= '0;
      wb_dat_q   <= '0;
      m_dat_q[0] <= '0;
      m_dat_q[1] <= '0;
      m_ack_q    <= 2'b00;
      m_err_q    <= 2'b00;
    end else begin
      m_ack_q <= 2'b00;
      m_err_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            gnt_q    <= pick;
            grant_q  <= pick ? 2'b10 : 2'b01;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            wb_we_q  <= p_we_q[pick];
            wb_adr_q <= p_adr_q[pick];
            wb_dat_q <= p_dat_q[pick];
            state_q  <= StIssue;
          end
        end
        StIssue, StWait: begin
          wb_cyc_q <= 1'b0;
          wb_stb_q <= 1'b0;
          if (done) begin
            if (done_err) begin
              m_err_q[gnt_q] <= 1'b1;
            end else begin
              m_ack_q[gnt_q] <= 1'b1;
              if (!wb_we_q) m_dat_q[gnt_q] <= wb_io.dat_s2m;
            end
            last_q  <= gnt_q;
            grant_q <= 2'b00;
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_io.cyc     = wb_cyc_q;
  assign wb_io.stb     = wb_stb_q;
  assign wb_io.we      = wb_we_q;
  assign wb_io.adr     = wb_adr_q;
  assign wb_io.dat_m2s = wb_dat_q;

  assign m0_io.dat_s2m = m_dat_q[0];
  assign m0_io.ack     = m_ack_q[0];
  assign m0_io.err     = m_err_q[0];
  assign m1_io.dat_s2m = m_dat_q[1];
  assign m1_io.ack     = m_ack_q[1];
  assign m1_io.err     = m_err_q[1];

  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Scoreboard bench for wb_req_arbiter: directed requests push expected bus
// strobes and master responses; a monitor pops and compares them.
module tb_wb_req_arbiter;

  typedef struct {
    bit          m;
    bit          we;
    logic [15:0] adr;
    logic [15:0] dat;
    int          cyc;
  } bus_t;

  typedef struct {
    bit          m;
    bit          err;
    logic [15:0] dat;
    logic [15:0] other;
    int          cyc;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;

  wb_req_arbiter_if m0 ();
  wb_req_arbiter_if m1 ();
  wb_req_arbiter_if wb ();

  wb_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .m0_io   (m0),
    .m1_io   (m1),
    .wb_io   (wb),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  bus_t bus_q [$];
  rsp_t rsp_q [$];

  // slave model controls
  bit          sl_respond;
  int          sl_delay;
  bit          sl_ack;
  bit          sl_err;
  logic [15:0] sl_data;
  int          kick_req  = 0;
  int          kick_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Slave model: responds sl_delay cycles after the strobe; a kick forces a stray ack.
  initial begin
    wb.ack     = 1'b0;
    wb.err     = 1'b0;
    wb.dat_s2m = '0;
    forever begin
      @(negedge clk);
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (kick_req != kick_done) begin
        kick_done  = kick_req;
        wb.ack     = 1'b1;
        wb.dat_s2m = 16'hDEAD;
      end else if (wb.stb && sl_respond) begin
        repeat (sl_delay) @(negedge clk);
        wb.ack     = sl_ack;
        wb.err     = sl_err;
        wb.dat_s2m = sl_data;
      end
    end
  end

  // Monitor: compares every bus strobe and every master completion pulse.
  bus_t be;
  rsp_t re;
  logic p0, p1;
  always @(negedge clk) begin
    if (wb.stb) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got strobe adr %0h expected none (cycle %0d)",
                 wb.adr, cyc_cnt);
      end else begin
        be = bus_q.pop_front();
        check("bus_cyc",   wb.cyc, 1);
        check("bus_we",    wb.we, be.we);
        check("bus_adr",   wb.adr, be.adr);
        check("bus_dat",   wb.dat_m2s, be.dat);
        check("bus_grant", grant, be.m ? 2'b10 : 2'b01);
        if (be.cyc != 0) check("bus_cycle", cyc_cnt, be.cyc);
      end
    end
    p0 = m0.ack | m0.err;
    p1 = m1.ack | m1.err;
    if (p0 && p1) begin
      checks++;
      errors++;
      $display("FAIL rsp_both: got pulses on both masters expected one (cycle %0d)", cyc_cnt);
    end else if (p0 || p1) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got m%0d ack/err expected none (cycle %0d)",
                 p1, cyc_cnt);
      end else begin
        re = rsp_q.pop_front();
        check("rsp_master", p1, re.m);
        check("rsp_err",    p1 ? m1.err : m0.err, re.err);
        check("rsp_ack",    p1 ? m1.ack : m0.ack, !re.err);
        check("rsp_dat",    p1 ? m1.dat_s2m : m0.dat_s2m, re.dat);
        check("rsp_other",  p1 ? m0.dat_s2m : m1.dat_s2m, re.other);
        check("rsp_cycle",  cyc_cnt, re.cyc);
      end
    end
  end

  task automatic drive(input bit e0, input bit we0, input logic [15:0] a0, input logic [15:0] d0,
                       input bit e1, input bit we1, input logic [15:0] a1, input logic [15:0] d1,
                       output int k);
    @(posedge clk); #1;
    m0.cyc = e0; m0.stb = e0; m0.we = we0; m0.adr = a0; m0.dat_m2s = d0;
    m1.cyc = e1; m1.stb = e1; m1.we = we1; m1.adr = a1; m1.dat_m2s = d1;
    k = cyc_cnt;
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    m0.cyc = 1'b0; m0.stb = 1'b0;
    m1.cyc = 1'b0; m1.stb = 1'b0;
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", bus_q.size() + rsp_q.size(), 0);
    repeat (extra) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_grant"},  grant, 2'b00);
    check({tag, "_wb_cyc"}, wb.cyc, 0);
    check({tag, "_wb_stb"}, wb.stb, 0);
    check({tag, "_wb_we"},  wb.we, 0);
    check({tag, "_wb_adr"}, wb.adr, 0);
    check({tag, "_wb_dat"}, wb.dat_m2s, 0);
    check({tag, "_m0_dat"}, m0.dat_s2m, 0);
    check({tag, "_m1_dat"}, m1.dat_s2m, 0);
    check({tag, "_pulses"}, {m0.ack, m0.err, m1.ack, m1.err}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int k, k2;
  initial begin
    reset = 1'b1;
    m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.adr = 0; m0.dat_m2s = 0;
    m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.adr = 0; m1.dat_m2s = 0;
    sl_respond = 1; sl_delay = 3; sl_ack = 1; sl_err = 0; sl_data = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    reset_checks("rst0");

    // m0 read, slave acks 3 cycles after strobe
    drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, k);
    bus_q.push_back('{0, 0, 16'h0010, 16'h0000, k + 2});
    rsp_q.push_back('{0, 0, 16'hBEEF, 16'h0000, k + 6});
    release_req();
    drain(4);

    // simultaneous writes after reset: m0 first, then m1
    do_reset();
    reset_checks("rst1");
    sl_delay = 1; sl_data = 16'h0000;
    drive(1, 1, 16'h0020, 16'h1234, 1, 1, 16'h0030, 16'h5678, k);
    bus_q.push_back('{0, 1, 16'h0020, 16'h1234, k + 2});
    bus_q.push_back('{1, 1, 16'h0030, 16'h5678, k + 5});
    rsp_q.push_back('{0, 0, 16'h0000, 16'h0000, k + 4});
    rsp_q.push_back('{1, 0, 16'h0000, 16'h0000, k + 7});
    release_req();
    drain(3);

    // single m0 write with a combinational ack in the issue cycle
    sl_delay = 0;
    drive(1, 1, 16'h0050, 16'h1111, 0, 0, 16'h0000, 16'h0000, k);
    bus_q.push_back('{0, 1, 16'h0050, 16'h1111, k + 2});
    rsp_q.push_back('{0, 0, 16'h0000, 16'h0000, k + 3});
    release_req();
    drain(3);

    // tie after m0 was served last: m1 wins
    drive(1, 1, 16'h0060, 16'h2222, 1, 1, 16'h0070, 16'h3333, k);
    bus_q.push_back('{1, 1, 16'h0070, 16'h3333, k + 2});
    bus_q.push_back('{0, 1, 16'h0060, 16'h2222, k + 4});
    rsp_q.push_back('{1, 0, 16'h0000, 16'h0000, k + 3});
    rsp_q.push_back('{0, 0, 16'h0000, 16'h0000, k + 5});
    release_req();
    drain(3);

    // m1 read, ack and err together: err only, read data not taken
    sl_delay = 2; sl_ack = 1; sl_err = 1; sl_data = 16'hCAFE;
    drive(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0090, 16'h0000, k);
    bus_q.push_back('{1, 0, 16'h0090, 16'h0000, k + 2});
    rsp_q.push_back('{1, 1, 16'h0000, 16'h0000, k + 5});
    release_req();
    drain(3);

    // second m0 strobe while the first is still pending is dropped
    sl_delay = 4; sl_err = 0; sl_data = 16'h4444;
    drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, k);
    bus_q.push_back('{0, 0, 16'h0010, 16'h0000, k + 2});
    rsp_q.push_back('{0, 0, 16'h4444, 16'h0000, k + 7});
    release_req();
    drive(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, k2);
    release_req();
    drain(8);

    // reset during WAIT, then a stray slave ack
    sl_respond = 0;
    drive(1, 0, 16'h0080, 16'h0000, 0, 0, 16'h0000, 16'h0000, k);
    bus_q.push_back('{0, 0, 16'h0080, 16'h0000, k + 2});
    release_req();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    reset_checks("rst2");
    kick_req++;
    repeat (4) @(posedge clk);
    #1;
    reset_checks("late_ack");
    // only the fresh m1 request may reach the bus
    sl_respond = 1; sl_delay = 1; sl_ack = 1; sl_err = 0; sl_data = 16'h5555;
    drive(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h00A0, 16'h0000, k);
    bus_q.push_back('{1, 0, 16'h00A0, 16'h0000, k + 2});
    rsp_q.push_back('{1, 0, 16'h5555, 16'h0000, k + 4});
    release_req();
    drain(5);

`ifdef WB_REQ_ARBITER_TIMEOUT_EN
    // silent slave: m0 times out 8 cycles after issue, then m1 is issued
    sl_respond = 0;
    drive(1, 0, 16'h00B0, 16'h0000, 1, 0, 16'h00C0, 16'h0000, k);
    bus_q.push_back('{0, 0, 16'h00B0, 16'h0000, k + 2});
    bus_q.push_back('{1, 0, 16'h00C0, 16'h0000, k + 11});
    rsp_q.push_back('{0, 1, 16'h0000, 16'h5555, k + 10});
    rsp_q.push_back('{1, 1, 16'h5555, 16'h0000, k + 19});
    release_req();
    drain(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
